sign_extend_pipe: RTL and testbench
===================================

SIGN_EXTEND_PIPE -- requirements
Module: sign_extend_pipe

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: `clk` and `rst`.
REQ-002 The block SHALL take parameter IN_W, default 16: immediate field width in bits.
REQ-003 The block SHALL take parameter OUT_W, default 32: result width in bits; legal only if OUT_W >= IN_W+2.
REQ-004 Port `clk`, input, 1 bit: rising-edge clock.
REQ-005 Port `rst`, input, 1 bit: asynchronous active-high reset.
REQ-006 Port `in_valid`, input, 1 bit: `instruction` and `mode` are valid this cycle.
REQ-007 Port `in_ready`, output, 1 bit: block accepts input this cycle.
REQ-008 Port `instruction`, input, IN_W bits: raw immediate field.
REQ-009 Port `mode`, input, 2 bits: extension mode, captured with `instruction`.
REQ-010 Port `out_valid`, output, 1 bit: `out` holds a result.
REQ-011 Port `out_ready`, input, 1 bit: downstream consumer accepts the result.
REQ-012 Port `out`, output, OUT_W bits: extended immediate.
REQ-013 Port `test`, output, 1 bit: sign bit (`instruction[IN_W-1]`) of the result currently on `out`.
REQ-014 Port `count`, output, 16 bits: number of results delivered since reset.

Function
REQ-015 The block SHALL register input on the `clk` edge where `in_valid && in_ready` (stage 1), compute the result, and register it in stage 2.
REQ-016 Stage 2 drives `out`, `test` and `out_valid`.
REQ-017 Latency SHALL be 2 cycles from input acceptance to `out_valid`, with no backpressure.
REQ-018 Throughput SHALL be one result per cycle while `out_ready` = 1.
REQ-019 The mode encoding SHALL be:
- mode 00: sign-extend `instruction` to OUT_W.
- mode 01: zero-extend.
- mode 10: upper, `instruction` placed at `out[OUT_W-1:OUT_W-IN_W]` with lower bits zero.
- mode 11: branch offset, sign-extend then shift left by 2 with LSBs zero.
REQ-020 A transfer SHALL occur when `valid && ready` on the same edge.
REQ-021 `out_valid`, `out` and `test` SHALL stay stable while `out_valid` = 1 and `out_ready` = 0.
REQ-022 Stage 2 advances when `!out_valid || out_ready`.
REQ-023 Stage 1 advances when it is empty or stage 2 advances.
REQ-024 `in_ready` = `!s1_valid || s2_advance` (combinational).
REQ-025 With both stages full and `out_ready` = 0, `in_ready` SHALL be 0 and no data SHALL be lost or duplicated.
REQ-026 When stage 2 is drained and refilled on the same edge, the new result SHALL appear with no bubble.
REQ-027 `count` SHALL increment by 1 on each edge with `out_valid && out_ready`.
REQ-028 `count` SHALL wrap from 0xFFFF to 0x0000 without a flag.
REQ-029 Results SHALL leave in acceptance order.
REQ-030 `mode` captured with each input SHALL apply to that input only.
REQ-031 `in_valid` = 1 with `in_ready` = 0 SHALL NOT capture data; the source must hold its data.

Reset
REQ-032 Asserting `rst` SHALL immediately, without waiting for `clk`, force:
- both stage valids to 0;
- `out_valid` = 0, `out` = 0, `test` = 0, `count` = 0;
- `in_ready` = 1 after release.
REQ-033 Reset mid-operation SHALL discard all in-flight data; no result accepted before reset appears afterwards.
REQ-034 The first input SHALL be accepted on the first rising edge after `rst` deasserts.

Verification
REQ-035 mode 00, `instruction` 0x1000, `out_ready` = 1: `out` = 0x00001000 and `test` = 0, two cycles after acceptance.
REQ-036 mode 00, `instruction` 0x9000: `out` = 0xFFFF9000 and `test` = 1.
- mode 01, 0x9000: `out` = 0x00009000.
- mode 10, 0x1234: `out` = 0x12340000.
- mode 11, 0x9000: `out` = 0xFFFE4000.
REQ-037 Stream 0x0001..0x0005 back-to-back with `out_ready` low for cycles 3-6:
- `in_ready` drops after two entries are held;
- `out` holds 0x00000001 stable;
- all five results delivered in order;
- `count` = 5.
REQ-038 Assert `rst` asynchronously between clock edges with two items in flight:
- `out_valid` and `count` go to 0 before the next edge;
- neither item appears after release.
REQ-039 Force `count` to 0xFFFE via 65534 transfers, then deliver 3 more: `count` = 0x0001.

Source files
------------

// File: rtl/sign_extend_pipe.sv
// sign_extend_pipe: two-stage valid/ready immediate extender (in: instruction+mode; out: out, test=source sign bit, count=results delivered)
module sign_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  instruction,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out,
  output logic             test,
  output logic [15:0]      count
);
  logic             s1_valid;
  logic [IN_W-1:0]  s1_instr;
  logic [1:0]       s1_mode;
  logic             s2_adv;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] res;
  always_comb begin
    s2_adv   = !out_valid || out_ready;
    in_ready = !s1_valid || s2_adv;
    sext     = {{(OUT_W-IN_W){s1_instr[IN_W-1]}}, s1_instr};
    res      = s1_mode == 2'b00 ? sext :
               s1_mode == 2'b01 ? {{(OUT_W-IN_W){1'b0}}, s1_instr} :
               s1_mode == 2'b10 ? {s1_instr, {(OUT_W-IN_W){1'b0}}} :
                                  {sext[OUT_W-3:0], 2'b00};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_instr  <= '0;
      s1_mode   <= '0;
      out_valid <= 1'b0;
      out       <= '0;
      test      <= 1'b0;
      count     <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_instr <= instruction;
          s1_mode  <= mode;
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out  <= res;
          test <= s1_instr[IN_W-1];
        end
      end
      if (out_valid && out_ready) count <= count + 16'd1;
    end
  end
endmodule

// File: tb/tb_sign_extend_pipe.sv
// tb_sign_extend_pipe: directed self-checking bench for sign_extend_pipe
module tb_sign_extend_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] instruction = '0;
  logic [1:0]  mode = '0;
  logic        in_ready;
  logic        out_valid;
  logic        test;
  logic [31:0] out;
  logic [15:0] count;
  int checks = 0;
  int errors = 0;
  sign_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .test(test), .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [15:0] ins, input logic [1:0] m, input logic [31:0] eo, input logic et, input string tag);
    instruction = ins;
    mode = m;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1 chk({tag, "_in_ready"}, in_ready, 1);
    step;
    in_valid = 1'b0;
    chk({tag, "_lat1"}, out_valid, 0);
    step;
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_out"}, out, eo);
    chk({tag, "_test"}, test, et);
    step;
    chk({tag, "_drain"}, out_valid, 0);
  endtask
  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    #2 rst = 1'b0;
  endtask
  initial begin
    int nxt;
    int got;
    logic acc;
    logic dlv;
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_test", test, 0);
    chk("rst_count", count, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rel_in_ready", in_ready, 1);
    send(16'h1000, 2'b00, 32'h00001000, 1'b0, "sx_pos");
    send(16'h9000, 2'b00, 32'hFFFF9000, 1'b1, "sx_neg");
    send(16'h9000, 2'b01, 32'h00009000, 1'b1, "zx");
    send(16'h1234, 2'b10, 32'h12340000, 1'b0, "upper");
    send(16'h9000, 2'b11, 32'hFFFE4000, 1'b1, "branch_neg");
    send(16'h7FFF, 2'b11, 32'h0001FFFC, 1'b0, "branch_pos");
    send(16'hFFFF, 2'b10, 32'hFFFF0000, 1'b1, "upper_ones");
    chk("count_after_sends", count, 7);
    do_reset;
    chk("reset2_count", count, 0);
    nxt = 1;
    got = 1;
    mode = 2'b00;
    for (int c = 0; c < 40 && got <= 5; c++) begin
      out_ready = !(c >= 2 && c <= 6);
      in_valid = (nxt <= 5);
      instruction = 16'(nxt);
      #1;
      acc = in_valid && in_ready;
      dlv = out_valid && out_ready;
      if (c == 4) begin
        chk("stall_in_ready", in_ready, 0);
        chk("stall_valid", out_valid, 1);
        chk("stall_out", out, 32'h00000001);
      end
      if (c == 6) chk("stall_out_hold", out, 32'h00000001);
      if (dlv) chk("stream_out", out, 32'(got));
      step;
      if (acc) nxt++;
      if (dlv) got++;
    end
    in_valid = 1'b0;
    chk("stream_all_delivered", 32'(got), 6);
    chk("stream_count", count, 5);
    out_ready = 1'b0;
    instruction = 16'h8001;
    in_valid = 1'b1;
    step;
    instruction = 16'h8002;
    step;
    in_valid = 1'b0;
    chk("inflight_valid", out_valid, 1);
    chk("inflight_test", test, 1);
    #3 rst = 1'b1;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_count", count, 0);
    chk("async_out", out, 0);
    chk("async_test", test, 0);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    #1 chk("async_in_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      step;
      chk("no_ghost", out_valid, 0);
    end
    chk("no_ghost_count", count, 0);
    do_reset;
    out_ready = 1'b1;
    instruction = 16'h0042;
    in_valid = 1'b1;
    repeat (65534) step;
    in_valid = 1'b0;
    repeat (3) step;
    chk("count_fffe", count, 16'hFFFE);
    in_valid = 1'b1;
    repeat (3) step;
    in_valid = 1'b0;
    repeat (3) step;
    chk("count_wrap", count, 16'h0001);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
